line_window_cache: RTL

Parametrised multi-row line cache between the single-port frame memory and the stencil accelerator. It fetches the input frame word by word and keeps the last ROWS-1 rows in internal delay lines. For every fetched word it presents one vertically aligned column of ROWS words. It also arbitrates accelerator write-back into the output frame region, and sequences a whole frame through an explicit start/done handshake.

---
 rtl/line_window_cache.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/line_window_cache.sv
// Multi-row line cache: streams a frame from memory, presents ROWS-tall columns
// through ROWS-1 row delay lines, and arbitrates accelerator write-back.
module line_window_cache #(
  parameter int unsigned WIDTH       = 352,
  parameter int unsigned HEIGHT      = 288,
  parameter int unsigned PX_PER_WORD = 4,
  parameter int unsigned ROWS        = 3,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned RD_BASE     = 0,
  parameter int unsigned WR_BASE     = WIDTH * HEIGHT / PX_PER_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          mem_addr,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [31:0]          mem_di,
  input  logic [31:0]          mem_do,
  input  logic                 rd_req,
  output logic                 rd_ack,
  input  logic                 wr_req,
  output logic                 wr_ack,
  input  logic [31:0]          wr_data,
  output logic                 col_valid,
  output logic [32*ROWS-1:0]   col_data,
  output logic [ROWS-1:0]      lane_valid
);

  localparam int unsigned ROW_WORDS   = WIDTH / PX_PER_WORD;
  localparam int unsigned FRAME_WORDS = ROW_WORDS * HEIGHT;
  localparam int unsigned CNT_W       = $clog2(FRAME_WORDS + 1);
  localparam int unsigned COL_W       = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int unsigned RD_W        = $clog2(ROWS);
  localparam int          NROWS       = int'(ROWS);

  if (WIDTH % PX_PER_WORD != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of PX_PER_WORD");
  end
  if (ROWS < 2 || ROWS > 7) begin : g_bad_rows
    $error("ROWS must be in 2..7");
  end
  if (HEIGHT < ROWS) begin : g_bad_height
    $error("HEIGHT must be at least ROWS");
  end
  if (WR_BASE + FRAME_WORDS > 65536) begin : g_bad_wr_base
    $error("output frame exceeds the 16-bit address space");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     rd_cnt, wr_cnt;
  logic [COL_W-1:0]     col;
  logic [RD_W-1:0]      rows_done;
  logic [MEM_LATENCY:0] pipe;
  logic                 start_frame, done_next, ret;
  logic [31:0]          word_in;
  logic [32*ROWS-1:0]   col_next;
  logic [ROWS-1:0]      lv_next;
  logic [31:0]          line_mem [ROWS-1][ROW_WORDS];

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and the combinational handshake; write wins over read.
  always_comb begin
    state_next  = state;
    wr_ack      = 1'b0;
    rd_ack      = 1'b0;
    start_frame = 1'b0;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          start_frame = 1'b1;
        end
      end
      RUN: begin
        wr_ack = wr_req && (wr_cnt < CNT_W'(FRAME_WORDS));
        rd_ack = rd_req && (rd_cnt < CNT_W'(FRAME_WORDS)) && !wr_ack;
        if (rd_cnt == CNT_W'(FRAME_WORDS) && wr_cnt == CNT_W'(FRAME_WORDS))
          state_next = DRAIN;
      end
      DRAIN: begin
        if (pipe == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next  = IDLE;
      start_frame = 1'b0;
      done_next   = 1'b0;
    end
  end

  assign ret     = pipe[MEM_LATENCY] && !abort;
  assign word_in = swap32(mem_do);

  // Assemble the column from the returning word and the delay-line outputs.
  always_comb begin
    col_next        = '0;
    col_next[31:0]  = word_in;
    for (int k = 1; k < NROWS; k++) col_next[32*k +: 32] = line_mem[k-1][col];
    lv_next = '0;
    for (int k = 0; k < NROWS; k++) lv_next[k] = (k <= int'(rows_done));
  end

  always_ff @(posedge clk) begin
    if (ret) begin
      line_mem[0][col] <= word_in;
      for (int k = 1; k < NROWS - 1; k++) line_mem[k][col] <= line_mem[k-1][col];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_addr   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_di     <= '0;
      col_valid  <= 1'b0;
      col_data   <= '0;
      lane_valid <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      col        <= '0;
      rows_done  <= '0;
      pipe       <= '0;
    end else begin
      busy   <= (state_next != IDLE);
      done   <= done_next;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (wr_ack && !abort) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b1;
        mem_addr <= 16'(WR_BASE + 32'(wr_cnt));
        mem_di   <= swap32(wr_data);
        wr_cnt   <= wr_cnt + CNT_W'(1);
      end else if (rd_ack && !abort) begin
        mem_en   <= 1'b1;
        mem_addr <= 16'(RD_BASE + 32'(rd_cnt));
        rd_cnt   <= rd_cnt + CNT_W'(1);
      end
      pipe[0] <= rd_ack && !abort;
      for (int i = 1; i <= int'(MEM_LATENCY); i++) pipe[i] <= pipe[i-1];
      col_valid <= ret;
      if (ret) begin
        col_data   <= col_next;
        lane_valid <= lv_next;
        if (col == COL_W'(ROW_WORDS - 1)) begin
          col <= '0;
          if (rows_done < RD_W'(ROWS - 1)) rows_done <= rows_done + RD_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      // Frame start and abort both discard progress and in-flight reads.
      if (start_frame || abort) begin
        rd_cnt    <= '0;
        wr_cnt    <= '0;
        col       <= '0;
        rows_done <= '0;
        pipe      <= '0;
      end
    end
  end

endmodule
